// File: rtl/jim_bus_master.sv
// jim_bus_master
//   Initiator end of the BBC 1MHz bus. It turns one host command at a time
//   into bus cycles: a select write to &FCFF, a page write to &FCFE, then the
//   data access in page &FD. A control command instead makes a single access
//   to &FCA0. Every bus cycle occupies one slot of CLK_DIV clk50 cycles.
//
// Parameters
//   CLK_DIV : clk50 cycles per bus slot (even, >= 8)
//   SEL_ID  : value placed in bits [7:3] of every &FCFF write
//
// Build option
//   JIM_PAGE_CACHE_EN : remember the last select/page values written and skip
//                       the &FCFF / &FCFE writes when they would not change.
//
// Ports
//   clk50, rst                 : system clock, synchronous active-high reset
//   cmd_valid / cmd_ready      : command handshake (ready only while idle)
//   cmd_rnw, cmd_ctrl          : read/not-write, control-register select
//   cmd_addr, cmd_wdata        : 19-bit RAM address, write data
//   rsp_valid, rsp_rdata       : one-cycle completion pulse, read data
//   clke, rnw, pgfc_n, pgfd_n  : 1MHz bus clock and strobes
//   bus_addr                   : bus address low byte
//   bus_data_out, bus_data_oe  : write data and its drive enable
//   bus_data_in                : read data from the bus
module jim_bus_master #(
  parameter int         CLK_DIV = 50,
  parameter logic [4:0] SEL_ID  = 5'b11001
) (
  input  logic        clk50,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_rnw,
  input  logic        cmd_ctrl,
  input  logic [18:0] cmd_addr,
  input  logic [7:0]  cmd_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic        clke,
  output logic        rnw,
  output logic        pgfc_n,
  output logic        pgfd_n,
  output logic [7:0]  bus_addr,
  output logic [7:0]  bus_data_out,
  output logic        bus_data_oe,
  input  logic [7:0]  bus_data_in
);

  localparam int              PH_W      = $clog2(CLK_DIV);
  localparam logic [PH_W-1:0] PH_LAST   = PH_W'(CLK_DIV - 1);
  localparam logic [PH_W-1:0] PH_HALF   = PH_W'(CLK_DIV / 2);
  // Bus signals are reloaded on the edge that moves ph from 1 to 2, which
  // gives two clk50 cycles of hold after clke falls.
  localparam logic [PH_W-1:0] PH_LAUNCH = PH_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEL,
    ST_PAGE,
    ST_ACCESS
  } state_t;

  state_t          state;
  logic [PH_W-1:0] ph;
  logic [PH_W-1:0] ph_next;
  logic            launch;
  logic            slot_end;
  logic            slot_live;

  logic            req_rnw;
  logic            req_ctrl;
  logic [18:0]     req_addr;
  logic [7:0]      req_wdata;

  logic            nx_fc_n;
  logic            nx_fd_n;
  logic            nx_rnw;
  logic [7:0]      nx_addr;
  logic [7:0]      nx_data;
  logic            nx_oe;

`ifdef JIM_PAGE_CACHE_EN
  logic            cache_valid;
  logic [2:0]      cache_hi;
  logic [7:0]      cache_mid;
  logic            req_skip_page;
  logic            hit_hi;
  logic            hit_mid;

  assign hit_hi  = cache_valid && (cache_hi == cmd_addr[18:16]);
  assign hit_mid = cache_valid && (cache_mid == cmd_addr[15:8]);
`endif

  always_comb begin
    ph_next = (ph == PH_LAST) ? '0 : ph + PH_W'(1);
  end

  assign launch   = (ph == PH_LAUNCH);
  // Last clock of clke high: the clke falling edge samples read data.
  assign slot_end = (ph == PH_LAST);

  // Free-running slot phase; clke is registered from the next phase so it
  // is glitch-free and falls exactly when ph wraps to 0.
  always_ff @(posedge clk50) begin
    if (rst) begin
      ph   <= '0;
      clke <= 1'b0;
    end else begin
      ph   <= ph_next;
      clke <= (ph_next >= PH_HALF);
    end
  end

  // Bus values for the slot the current state is about to occupy.
  always_comb begin
    nx_fc_n = 1'b1;
    nx_fd_n = 1'b1;
    nx_rnw  = 1'b1;
    nx_addr = 8'hFF;
    nx_data = 8'h00;
    nx_oe   = 1'b0;
    case (state)
      ST_SEL: begin
        nx_fc_n = 1'b0;
        nx_rnw  = 1'b0;
        nx_addr = 8'hFF;
        nx_data = {SEL_ID, req_addr[18:16]};
        nx_oe   = 1'b1;
      end
      ST_PAGE: begin
        nx_fc_n = 1'b0;
        nx_rnw  = 1'b0;
        nx_addr = 8'hFE;
        nx_data = req_addr[15:8];
        nx_oe   = 1'b1;
      end
      ST_ACCESS: begin
        if (req_ctrl) begin
          nx_fc_n = 1'b0;
          nx_addr = 8'hA0;
        end else begin
          nx_fd_n = 1'b0;
          nx_addr = req_addr[7:0];
        end
        nx_rnw = req_rnw;
        if (!req_rnw) begin
          nx_data = req_wdata;
          nx_oe   = 1'b1;
        end
      end
      default: begin
        nx_fc_n = 1'b1;
      end
    endcase
  end

  // Bus outputs only change at the launch point of a slot.
  always_ff @(posedge clk50) begin
    if (rst) begin
      pgfc_n       <= 1'b1;
      pgfd_n       <= 1'b1;
      rnw          <= 1'b1;
      bus_addr     <= 8'hFF;
      bus_data_out <= 8'h00;
      bus_data_oe  <= 1'b0;
    end else if (launch) begin
      pgfc_n       <= nx_fc_n;
      pgfd_n       <= nx_fd_n;
      rnw          <= nx_rnw;
      bus_addr     <= nx_addr;
      bus_data_out <= nx_data;
      bus_data_oe  <= nx_oe;
    end
  end

  // Command sequencer. slot_live marks that the current state's slot has
  // actually been launched, so a command accepted late in a slot waits for
  // the next launch rather than ending at the first slot_end it sees.
  always_ff @(posedge clk50) begin
    if (rst) begin
      state     <= ST_IDLE;
      slot_live <= 1'b0;
      cmd_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= 8'h00;
      req_rnw   <= 1'b1;
      req_ctrl  <= 1'b0;
      req_addr  <= '0;
      req_wdata <= 8'h00;
`ifdef JIM_PAGE_CACHE_EN
      cache_valid   <= 1'b0;
      cache_hi      <= 3'b000;
      cache_mid     <= 8'h00;
      req_skip_page <= 1'b0;
`endif
    end else begin
      rsp_valid <= 1'b0;
      if (launch && (state != ST_IDLE)) begin
        slot_live <= 1'b1;
      end
      case (state)
        ST_IDLE: begin
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            slot_live <= 1'b0;
            req_rnw   <= cmd_rnw;
            req_ctrl  <= cmd_ctrl;
            req_addr  <= cmd_addr;
            req_wdata <= cmd_wdata;
`ifdef JIM_PAGE_CACHE_EN
            req_skip_page <= hit_mid;
            if (cmd_ctrl) begin
              state <= ST_ACCESS;
            end else if (!hit_hi) begin
              state <= ST_SEL;
            end else if (!hit_mid) begin
              state <= ST_PAGE;
            end else begin
              state <= ST_ACCESS;
            end
`else
            state <= cmd_ctrl ? ST_ACCESS : ST_SEL;
`endif
          end
        end
        ST_SEL: begin
          if (slot_live && slot_end) begin
            slot_live <= 1'b0;
`ifdef JIM_PAGE_CACHE_EN
            cache_hi <= req_addr[18:16];
            state    <= req_skip_page ? ST_ACCESS : ST_PAGE;
`else
            state    <= ST_PAGE;
`endif
          end
        end
        ST_PAGE: begin
          if (slot_live && slot_end) begin
            slot_live <= 1'b0;
            state     <= ST_ACCESS;
`ifdef JIM_PAGE_CACHE_EN
            // Both halves are current once a page write lands, because a
            // select write (if needed) always precedes it.
            cache_mid   <= req_addr[15:8];
            cache_valid <= 1'b1;
`endif
          end
        end
        ST_ACCESS: begin
          if (slot_live && slot_end) begin
            slot_live <= 1'b0;
            state     <= ST_IDLE;
            cmd_ready <= 1'b1;
            rsp_valid <= 1'b1;
            rsp_rdata <= req_rnw ? bus_data_in : 8'h00;
`ifdef JIM_PAGE_CACHE_EN
            // A control write may reset the paging logic on the far side.
            if (req_ctrl && !req_rnw) begin
              cache_valid <= 1'b0;
            end
`endif
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/jim_bus_master.md
Name: jim_bus_master

Overview:
- Initiator end of the BBC 1MHz bus, driving the same page-FC/FD protocol the life engine responds to: clke, rnw, pgfc_n, pgfd_n, bus_addr, bus_data.
- Turns host commands into 1MHz bus cycles: paging writes to &FCFF/&FCFE, then a data access in page &FD or a control write/read at &FCA0.
- Used as a bench/host-side driver, and in a future standalone host FPGA to load and inspect life patterns.

Parameters:
- CLK_DIV, 50: clk50 cycles per bus cycle (slot); must be even and >= 8.
- SEL_ID, 5'b11001: value placed in bits [7:3] of every &FCFF write.

Ports:
- clk50  in  1  system clock
- rst  in  1  synchronous reset, active-high
- cmd_valid  in  1  command request
- cmd_ready  out  1  high only in IDLE; command accepted on cmd_valid && cmd_ready
- cmd_rnw  in  1  1 = read, 0 = write
- cmd_ctrl  in  1  1 = control register &FCA0, 0 = paged RAM
- cmd_addr  in  19  RAM address; ignored when cmd_ctrl=1
- cmd_wdata  in  8  write data
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  8  read data; 8'h00 for writes
- clke  out  1  1MHz bus clock
- rnw  out  1  bus read/not-write
- pgfc_n  out  1  page &FC select
- pgfd_n  out  1  page &FD select
- bus_addr  out  8  bus address low byte
- bus_data_out  out  8  write data
- bus_data_oe  out  1  drive enable for bus_data_out
- bus_data_in  in  8  sampled read data

Behaviour:
- Slot phase counter ph: 0..CLK_DIV-1, free-running. clke = (ph >= CLK_DIV/2); clke falls at ph=0.
- Bus signal update:
  - rnw, pgfc_n, pgfd_n, bus_addr, bus_data_out and bus_data_oe change only on the clock where ph==2. This gives 2 clk50 of hold after the clke falling edge.
  - An idle slot drives pgfc_n=1, pgfd_n=1, rnw=1, bus_data_oe=0, bus_addr=8'hFF.
  - bus_data_oe=1 only in write slots.
- Read data: bus_data_in is sampled at ph==CLK_DIV-1, the last clock of clke high.
- States: IDLE -> SEL -> PAGE -> ACCESS -> IDLE. Each bus state occupies exactly one slot, starting at the next ph==2 after entry.
  - IDLE: cmd_ready=1. Acceptance latches rnw/ctrl/addr/wdata. Next state is ACCESS if cmd_ctrl=1, otherwise SEL.
  - SEL: write &FCFF, data {SEL_ID, addr[18:16]}.
  - PAGE: write &FCFE, data addr[15:8].
  - ACCESS, ctrl=0: page &FD, bus_addr = addr[7:0], rnw = cmd_rnw.
  - ACCESS, ctrl=1: page &FC, bus_addr = 8'hA0, rnw = cmd_rnw.
- Completion: rsp_valid pulses on the clock after the ACCESS slot's ph==CLK_DIV-1 sample point. rsp_rdata holds its value until the next response.
- Latency: RAM access is 3 slots plus wait for the next ph==2. Control access is 1 slot plus the same wait.
- A command arriving while busy stalls (cmd_ready=0). No queueing.
- Address wrap: cmd_addr = 19'h7FFFF is legal and gives &FCFF data {SEL_ID,3'b111}, &FCFE FF, &FD offset FF.
- Reset, including mid-operation: state=IDLE, ph=0 (clke=0), pgfc_n=1, pgfd_n=1, rnw=1, bus_addr=8'hFF, bus_data_oe=0, bus_data_out=0, rsp_valid=0, rsp_rdata=0, page cache invalid. No response is issued for an aborted command.

Optional Feature:
- Macro JIM_PAGE_CACHE_EN.
- Defined:
  - Keep cached_hi[2:0] and cached_mid[7:0] plus a valid bit, set after each successful SEL/PAGE write.
  - Skip SEL when addr[18:16] matches the cache; skip PAGE when addr[15:8] matches.
  - A same-page RAM access therefore takes 1 slot.
  - Invalidate the cache on reset and after any control write to &FCA0.
- Undefined: SEL and PAGE are always issued.

Test Plan:
- Reset, then idle 3 slots: clke toggles with period CLK_DIV; pgfc_n=pgfd_n=1, rnw=1, bus_data_oe=0 throughout.
- Write addr=19'h2_3456, data=8'hA5:
  - Slot 1 = &FCFF with data 8'hCA.
  - Slot 2 = &FCFE with 8'h34.
  - Slot 3 = pgfd_n=0, bus_addr=8'h56, data 8'hA5, oe=1.
  - rsp_valid once with rdata=8'h00.
  - Signals stable from ph=2 through ph=1 of the next slot.
- Read ctrl=1, bus_data_in=8'h80 at sample point: single &FCA0 read slot; rsp_rdata=8'h80.
- Read addr=19'h7FFFF, bus_data_in=8'h3C: slots carry &FCFF 8'hCF, &FCFE 8'hFF, &FD offset FF; rsp_rdata=8'h3C.
- Assert rst during the PAGE slot: next clock has all selects idle and clke=0; no rsp_valid; cmd_ready=1 after reset.
- With JIM_PAGE_CACHE_EN, two reads to 19'h0_1200 then 19'h0_12FF: the second uses 1 slot, with no &FCFF/&FCFE writes.
